// File: rtl/ps2_matrix_mapper.sv
// ps2_matrix_mapper: PS/2 set-2 scancode bytes -> active-low ROWS x COLS key matrix.
// A 512-entry loadable table maps {ext,code} to {valid,row,col}. The table is cleared
// after reset. The mapper handles the E0/F0 prefixes, the E1 Pause sequence, the
// reset/overflow codes, a RESTORE key and a prefix timeout.
module ps2_matrix_mapper #(
    parameter int          ROWS           = 8,
    parameter int          COLS           = 8,
    parameter logic [8:0]  RESTORE_CODE   = 9'h17D,
    parameter int          PREFIX_TIMEOUT = 1000000,
    localparam int         RW             = $clog2(ROWS),
    localparam int         CW             = $clog2(COLS),
    localparam int         MAPW           = 1 + RW + CW,
    localparam int         KW             = $clog2(ROWS*COLS+1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      data,
    input  logic            data_rdy,
    input  logic [ROWS-1:0] scan_in,
    output logic [COLS-1:0] scan_out,
    input  logic            map_we,
    input  logic [8:0]      map_addr,
    input  logic [MAPW-1:0] map_wdata,
    output logic            map_busy,
    output logic            restore_n,
    output logic [KW-1:0]   keys_down
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(PREFIX_TIMEOUT - 1);
    localparam logic [KW-1:0] KEY_ONE = {{(KW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_SKIP = 2'd2} state_t;

    state_t                 state_r, state_nxt_s;
    logic [8:0]             init_addr_r;
    logic [2:0]             skip_cnt_r;
    logic                   brk_r, ext_r;
    logic [TW-1:0]          to_cnt_r;
    logic                   lk_vld_r, press_r;
    logic [8:0]             key_r;
    logic [MAPW-1:0]        mem_r [512];
    logic [MAPW-1:0]        ram_q_r;
    logic                   ram_we_s;
    logic [8:0]             ram_waddr_s;
    logic [MAPW-1:0]        ram_wdata_s;
    logic                   busy_nxt_s;
    logic                   map_busy_r, restore_n_r;
    logic [ROWS*COLS-1:0]   matrix_r, matrix_nxt_s;
    logic [KW-1:0]          keys_down_r, keys_nxt_s;
    logic                   restore_nxt_s;
    logic                   set_brk_s, set_ext_s, go_skip_s, rel_all_s, lookup_s;
    int                     row_i_s, col_i_s, idx_s;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: INIT clear sweep, Pause skip count
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_addr_r == 9'h1FF) state_nxt_s = ST_IDLE;
                else                       state_nxt_s = ST_INIT;
            end
            ST_IDLE: begin
                if (go_skip_s) state_nxt_s = ST_SKIP;
                else           state_nxt_s = ST_IDLE;
            end
            ST_SKIP: begin
                if (data_rdy && (skip_cnt_r == 3'd1)) state_nxt_s = ST_IDLE;
                else                                  state_nxt_s = ST_SKIP;
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Output logic: table write port mux and busy flag
    always_comb begin
        busy_nxt_s = (state_nxt_s == ST_INIT);
        if (state_r == ST_INIT) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = init_addr_r;
            ram_wdata_s = {MAPW{1'b0}};
        end else begin
            ram_we_s    = map_we;
            ram_waddr_s = map_addr;
            ram_wdata_s = map_wdata;
        end
    end

    // Byte classification, only acted on in IDLE
    always_comb begin
        set_brk_s = 1'b0;
        set_ext_s = 1'b0;
        go_skip_s = 1'b0;
        rel_all_s = 1'b0;
        lookup_s  = 1'b0;
        if ((state_r == ST_IDLE) && data_rdy) begin
            case (data)
                8'hF0: set_brk_s = 1'b1;
                8'hE0: set_ext_s = 1'b1;
                8'hE1: go_skip_s = 1'b1;
                8'hAA, 8'h00, 8'hFF: begin
                    if (!(brk_r || ext_r)) rel_all_s = 1'b1;
                    else                   lookup_s  = 1'b1;
                end
                8'hFA, 8'hFE: lookup_s = 1'b0;
                default: lookup_s = 1'b1;
            endcase
        end else begin
            lookup_s = 1'b0;
        end
    end

    // Sequencing counters, prefix flags with timeout, stage-1 lookup latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_addr_r <= 9'd0;
            skip_cnt_r  <= 3'd0;
            brk_r       <= 1'b0;
            ext_r       <= 1'b0;
            to_cnt_r    <= {TW{1'b0}};
            lk_vld_r    <= 1'b0;
            press_r     <= 1'b0;
            key_r       <= 9'd0;
            map_busy_r  <= 1'b1;
        end else begin
            map_busy_r <= busy_nxt_s;
            if (state_r == ST_INIT) init_addr_r <= init_addr_r + 9'd1;
            if (go_skip_s) begin
                skip_cnt_r <= 3'd7;
            end else if ((state_r == ST_SKIP) && data_rdy) begin
                skip_cnt_r <= skip_cnt_r - 3'd1;
            end
            lk_vld_r <= lookup_s;
            if (lookup_s) begin
                key_r   <= {ext_r, data};
                press_r <= ~brk_r;
            end
            if (go_skip_s || lookup_s) begin
                brk_r    <= 1'b0;
                ext_r    <= 1'b0;
                to_cnt_r <= {TW{1'b0}};
            end else begin
                if (set_brk_s) brk_r <= 1'b1;
                if (set_ext_s) ext_r <= 1'b1;
                if (data_rdy) begin
                    to_cnt_r <= {TW{1'b0}};
                end else if (brk_r || ext_r) begin
                    if (to_cnt_r == TO_LAST) begin
                        brk_r    <= 1'b0;
                        ext_r    <= 1'b0;
                        to_cnt_r <= {TW{1'b0}};
                    end else begin
                        to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    to_cnt_r <= {TW{1'b0}};
                end
            end
        end
    end

    // Map table: read-first synchronous RAM, lookup address presented in the byte cycle
    always_ff @(posedge clk) begin
        if (ram_we_s) mem_r[ram_waddr_s] <= ram_wdata_s;
        ram_q_r <= mem_r[{ext_r, data}];
    end

    // Stage-2 matrix/keys/restore update; release-all overrides
    always_comb begin
        matrix_nxt_s  = matrix_r;
        keys_nxt_s    = keys_down_r;
        restore_nxt_s = restore_n_r;
        row_i_s       = int'(ram_q_r[RW+CW-1:CW]);
        col_i_s       = int'(ram_q_r[CW-1:0]);
        idx_s         = row_i_s * COLS + col_i_s;
        if (lk_vld_r) begin
            if (key_r == RESTORE_CODE) begin
                restore_nxt_s = ~press_r;
            end else if (ram_q_r[MAPW-1] && (row_i_s < ROWS) && (col_i_s < COLS)) begin
                if (press_r && matrix_r[idx_s]) begin
                    matrix_nxt_s[idx_s] = 1'b0;
                    keys_nxt_s          = keys_down_r + KEY_ONE;
                end else if (!press_r && !matrix_r[idx_s]) begin
                    matrix_nxt_s[idx_s] = 1'b1;
                    keys_nxt_s          = keys_down_r - KEY_ONE;
                end else begin
                    keys_nxt_s = keys_down_r;
                end
            end else begin
                keys_nxt_s = keys_down_r;
            end
        end else begin
            keys_nxt_s = keys_down_r;
        end
        if (rel_all_s) begin
            matrix_nxt_s  = {(ROWS*COLS){1'b1}};
            keys_nxt_s    = {KW{1'b0}};
            restore_nxt_s = 1'b1;
        end else begin
            restore_nxt_s = restore_nxt_s;
        end
    end

    // Matrix, key count and restore registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix_r    <= {(ROWS*COLS){1'b1}};
            keys_down_r <= {KW{1'b0}};
            restore_n_r <= 1'b1;
        end else begin
            matrix_r    <= matrix_nxt_s;
            keys_down_r <= keys_nxt_s;
            restore_n_r <= restore_nxt_s;
        end
    end

    // Column sense: AND of the matrix bits of every driven (low) row
    always_comb begin
        scan_out = {COLS{1'b1}};
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!scan_in[r]) scan_out[c] = scan_out[c] & matrix_r[r*COLS + c];
                else             scan_out[c] = scan_out[c];
            end
        end
    end

    assign map_busy  = map_busy_r;
    assign restore_n = restore_n_r;
    assign keys_down = keys_down_r;

endmodule

// File: tb/tb_ps2_matrix_mapper.sv
// Directed bench for ps2_matrix_mapper with an expected-state scoreboard queue.
module tb_ps2_matrix_mapper;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] data;
    logic       data_rdy;
    logic [7:0] scan_in;
    logic [7:0] scan_out;
    logic       map_we;
    logic [8:0] map_addr;
    logic [6:0] map_wdata;
    logic       map_busy;
    logic       restore_n;
    logic [6:0] keys_down;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] si;
        logic [7:0] sc;
        logic [6:0] kd;
        logic       rs;
    } exp_t;
    exp_t sb_q[$];

    ps2_matrix_mapper #(.ROWS(8), .COLS(8), .RESTORE_CODE(9'h17D), .PREFIX_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .data(data), .data_rdy(data_rdy),
        .scan_in(scan_in), .scan_out(scan_out), .map_we(map_we), .map_addr(map_addr),
        .map_wdata(map_wdata), .map_busy(map_busy), .restore_n(restore_n), .keys_down(keys_down)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data     = b;
        data_rdy = 1'b1;
        @(negedge clk);
        data_rdy = 1'b0;
    endtask

    task automatic map_write(input logic [8:0] a, input logic [6:0] w);
        @(negedge clk);
        map_we    = 1'b1;
        map_addr  = a;
        map_wdata = w;
        @(negedge clk);
        map_we    = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] si, input logic [7:0] sc,
                            input logic [6:0] kd, input logic rs);
        exp_t e;
        e.si = si; e.sc = sc; e.kd = kd; e.rs = rs;
        sb_q.push_back(e);
    endtask

    // pop one expectation once the pipeline has settled and compare it
    task automatic check_exp(input string tag);
        exp_t e;
        repeat (3) @(negedge clk);
        e = sb_q.pop_front();
        scan_in = e.si;
        #1;
        checks++;
        assert (scan_out === e.sc) else begin
            errors++;
            $error("FAIL %s scan_out observed %h expected %h", tag, scan_out, e.sc);
        end
        checks++;
        assert (keys_down === e.kd) else begin
            errors++;
            $error("FAIL %s keys_down observed %0d expected %0d", tag, keys_down, e.kd);
        end
        checks++;
        assert (restore_n === e.rs) else begin
            errors++;
            $error("FAIL %s restore_n observed %b expected %b", tag, restore_n, e.rs);
        end
    endtask

    initial begin
        int busy_cycles;
        reset_n = 1'b0; data = 8'h00; data_rdy = 1'b0; scan_in = 8'hFF;
        map_we = 1'b0; map_addr = 9'd0; map_wdata = 7'd0;
        repeat (3) @(negedge clk);
        checks++;
        assert (map_busy === 1'b1) else begin
            errors++;
            $error("FAIL reset_busy observed %b expected 1", map_busy);
        end
        reset_n = 1'b1;
        busy_cycles = 0;
        while (map_busy === 1'b1 && busy_cycles < 2000) begin
            busy_cycles++;
            @(negedge clk);
        end
        checks++;
        assert (busy_cycles === 512) else begin
            errors++;
            $error("FAIL init_len observed %0d expected 512", busy_cycles);
        end
        push_exp(8'h00, 8'hFF, 7'd0, 1'b1);
        check_exp("reset_state");

        // basic make / break
        map_write(9'h01C, {1'b1, 3'd1, 3'd2});
        send_byte(8'h1C);
        push_exp(8'hFD, 8'hFB, 7'd1, 1'b1);
        check_exp("make_1c");
        push_exp(8'hFF, 8'hFF, 7'd1, 1'b1);
        check_exp("all_rows_high");
        send_byte(8'hF0); send_byte(8'h1C);
        push_exp(8'hFD, 8'hFF, 7'd0, 1'b1);
        check_exp("break_1c");

        // extended key; plain code of the same byte is unmapped
        map_write(9'h16C, {1'b1, 3'd6, 3'd3});
        send_byte(8'hE0); send_byte(8'h6C);
        push_exp(8'hBF, 8'hF7, 7'd1, 1'b1);
        check_exp("ext_make_6c");
        send_byte(8'h6C);
        push_exp(8'hBF, 8'hF7, 7'd1, 1'b1);
        check_exp("plain_6c_unmapped");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6C);
        push_exp(8'hBF, 8'hFF, 7'd0, 1'b1);
        check_exp("ext_break_6c");

        // Pause sequence is skipped, IDLE afterwards
        map_write(9'h014, {1'b1, 3'd0, 3'd0});
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        push_exp(8'h00, 8'hFF, 7'd0, 1'b1);
        check_exp("pause_skipped");
        send_byte(8'h14);
        push_exp(8'hFE, 8'hFE, 7'd1, 1'b1);
        check_exp("after_pause_make_14");

        // F0 prefix expires: following 1C is a make
        send_byte(8'hF0);
        repeat (20) @(negedge clk);
        send_byte(8'h1C);
        push_exp(8'hFD, 8'hFB, 7'd2, 1'b1);
        check_exp("prefix_timeout");

        // typematic repeat does not count twice
        send_byte(8'h1C);
        push_exp(8'hFD, 8'hFB, 7'd2, 1'b1);
        check_exp("typematic");

        // three keys held, then AA releases all
        send_byte(8'hE0); send_byte(8'h6C);
        push_exp(8'h00, 8'hF2, 7'd3, 1'b1);
        check_exp("three_held");
        send_byte(8'hAA);
        push_exp(8'h00, 8'hFF, 7'd0, 1'b1);
        check_exp("release_all");

        // RESTORE key, never touches matrix
        send_byte(8'hE0); send_byte(8'h7D);
        push_exp(8'h00, 8'hFF, 7'd0, 1'b0);
        check_exp("restore_make");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h7D);
        push_exp(8'h00, 8'hFF, 7'd0, 1'b1);
        check_exp("restore_break");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
